pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage ARM pipeline. Takes the load-use hazard flag, EXE-stage branch resolution and the MEM-stage SRAM handshake, and drives the freeze, flush and bubble controls for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It also enforces a memory-wait watchdog and keeps a saturating stall-cycle counter for performance debug.

## Interface
- MEM_TIMEOUT, 64: consecutive not-ready SRAM cycles before the watchdog trips; legal range is 1..1023.
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- hazard_detected  in  1  load-use/RAW hazard on the instruction in ID
- branch_taken  in  1  branch resolved taken in EXE this cycle
- mem_req  in  1  MEM stage holds a load or store (MEM_R_EN | MEM_W_EN)
- sram_ready  in  1  SRAM access completes this cycle
- stat_clr  in  1  synchronous clear of stall_count
- freeze_pc  out  1  hold PC
- freeze_if_id  out  1  hold IF/ID register
- bubble_id_exe  out  1  load NOP into ID/EXE
- flush_if_id  out  1  squash IF/ID contents
- freeze_all  out  1  hold every pipeline register, including PC
- mem_timeout  out  1  sticky watchdog error
- stall_count  out  CNT_W  saturating count of stall cycles
- ctrl_state  out  2  current FSM state (debug)

## Operation
- FSM states: RUN=0, MEM_WAIT=1, TIMEOUT=2. Encoding 3 is illegal and recovers to RUN.
- Control outputs are Mealy, derived from the state and the current inputs. They react in the same cycle, with no registered latency.
- Priority in the evaluation of RUN, from highest to lowest:
  1. mem_req && !sram_ready: freeze_all=1 and next state MEM_WAIT. Branch and hazard are ignored.
  2. branch_taken: flush_if_id=1 and bubble_id_exe=1, with no freeze. A hazard in the same cycle is ignored because its instruction is squashed.
  3. hazard_detected: freeze_pc=1, freeze_if_id=1, bubble_id_exe=1.
  4. Otherwise all controls are 0.
- freeze_all=1 also forces freeze_pc=1 and freeze_if_id=1. It forces bubble_id_exe=0 and flush_if_id=0.
- MEM_WAIT:
  - While sram_ready=0: freeze_all=1.
  - When sram_ready=1: freeze_all=0, outputs follow RUN priorities 2–4, and next state is RUN. mem_req is still high in that cycle and must not re-enter MEM_WAIT.
- TIMEOUT:
  - freeze_all=1 and mem_timeout=1 are held until reset.
  - sram_ready, branch_taken and hazard_detected are ignored.
- Watchdog, wait_cnt (10 bits):
  - Loaded with 1 on entry from RUN and incremented on each further not-ready cycle in MEM_WAIT.
  - If the cycle in which wait_cnt==MEM_TIMEOUT also has sram_ready=0, next state is TIMEOUT.
  - Cleared on every return to RUN.
- stall_count:
  - Increments by 1 in each cycle where freeze_pc=1, whatever the cause. Flush-only cycles do not count.
  - Saturates at all-ones.
  - stat_clr has priority over increment; the cleared value is 0 the next cycle.
- Reset (rst=0 at a clk edge): state RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
- While rst=0, every control output is forced to 0.

## Timing
- Hazard stall: freeze_pc/freeze_if_id/bubble_id_exe are high in the same cycle as hazard_detected and drop when it drops. No extra cycle is added.
- Branch: a single flush cycle, coincident with branch_taken.
- SRAM access of N cycles, where the ready cycle is cycle N: freeze_all is high for exactly N-1 cycles. N=1 (ready in the first cycle) means zero freeze cycles and no state change.
- Timeout:
  - Occurs after MEM_TIMEOUT consecutive not-ready cycles.
  - mem_timeout and ctrl_state=2 are visible from the following cycle.
  - sram_ready arriving in the MEM_TIMEOUT-th cycle completes normally.
- Reset mid-MEM_WAIT aborts the wait. The next cycle evaluates as RUN.

## Structure
- The shared package pipeline_ctrl_pkg holds:
  - the state encodings RUN/MEM_WAIT/TIMEOUT;
  - the 2-bit state width;
  - the default MEM_TIMEOUT and CNT_W.
- One sub-module: sat_counter (parameterised width, sync active-low reset, clr, inc, saturating). It is instantiated for stall_count.

## Test plan
- Reset, then hazard_detected=1 for 2 cycles: freeze_pc/freeze_if_id/bubble_id_exe are high for exactly 2 cycles and stall_count=2.
- branch_taken=1 and hazard_detected=1 in the same cycle: flush_if_id=1, bubble_id_exe=1, freeze_pc=0, and stall_count is unchanged.
- mem_req=1 with sram_ready rising on the 4th cycle, plus branch_taken=1 in cycles 2 and 4:
  - freeze_all is high in cycles 1–3 and the branch in cycle 2 is ignored.
  - Cycle 4 gives flush_if_id=1 and freeze_all=0.
  - State returns to RUN and stall_count=3.
- MEM_TIMEOUT=8, sram_ready held 0: mem_timeout=1 and ctrl_state=2 from cycle 9. It stays set after sram_ready=1 and clears only on rst=0.
- Force stall_count to near saturation with CNT_W=4 (15 stall cycles, then 3 more): it holds at 15. stat_clr=1 with a concurrent stall gives 0 the next cycle.
- rst=0 asserted during MEM_WAIT: outputs are 0 during reset. Afterwards the state is RUN, and mem_req with sram_ready=1 causes no freeze.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Holds the FSM encoding, the packed control bundle and the RUN-priority helper.
package pipeline_ctrl_pkg;

  localparam int STATE_W         = 2;
  localparam int WAIT_W          = 10;
  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic bubble_id_exe;
    logic flush_if_id;
    logic freeze_all;
  } ctrl_out_t;

  // Branch beats hazard: the hazarding instruction is squashed by the flush.
  function automatic ctrl_out_t run_priority(input logic branch_taken,
                                             input logic hazard_detected);
    ctrl_out_t c;
    c = '0;
    if (branch_taken) begin
      c.flush_if_id   = 1'b1;
      c.bubble_id_exe = 1'b1;
    end else if (hazard_detected) begin
      c.freeze_pc     = 1'b1;
      c.freeze_if_id  = 1'b1;
      c.bubble_id_exe = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Bundle of hazard/branch/SRAM inputs and freeze/flush/debug outputs.
// Handshake: a MEM access is outstanding while mem_req=1 and completes in the
// first cycle that also has sram_ready=1; mem_req stays high through that cycle.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             stat_clr;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             bubble_id_exe;
  logic             flush_if_id;
  logic             freeze_all;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       ctrl_state;

  modport master (
    output hazard_detected, branch_taken, mem_req, sram_ready, stat_clr,
    input  freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_all,
    input  mem_timeout, stall_count, ctrl_state
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_req, sram_ready, stat_clr,
    output freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_all,
    output mem_timeout, stall_count, ctrl_state
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy freeze/flush/bubble
// controls, SRAM wait watchdog and a saturating stall-cycle counter.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic                        clk,
  input logic                        rst,
  pipeline_stall_controller_if.slave bus
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_t       state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next, cur_wait;
  logic              mem_timeout_q;
  ctrl_out_t         ctl;
  logic [CNT_W-1:0]  stall_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_RUN;
      wait_cnt      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (state_next == ST_TIMEOUT) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

  // cur_wait is the ordinal of the current not-ready cycle within the access.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    ctl        = '0;
    cur_wait   = wait_cnt + 1'b1;
    case (state)
      ST_RUN: begin
        if (bus.mem_req && !bus.sram_ready) begin
          ctl.freeze_all = 1'b1;
          if (TIMEOUT_LIM <= 1) begin
            state_next = ST_TIMEOUT;
            wait_next  = '0;
          end else begin
            state_next = ST_MEM_WAIT;
            wait_next  = WAIT_W'(1);
          end
        end else begin
          ctl = run_priority(bus.branch_taken, bus.hazard_detected);
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.sram_ready) begin
          ctl.freeze_all = 1'b1;
          if (cur_wait >= TIMEOUT_LIM) begin
            state_next = ST_TIMEOUT;
            wait_next  = '0;
          end else begin
            wait_next = cur_wait;
          end
        end else begin
          // Completion cycle: mem_req is still high but must not re-arm the wait.
          ctl        = run_priority(bus.branch_taken, bus.hazard_detected);
          state_next = ST_RUN;
          wait_next  = '0;
        end
      end
      ST_TIMEOUT: begin
        ctl.freeze_all = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
        wait_next  = '0;
      end
    endcase

    if (ctl.freeze_all) begin
      ctl.freeze_pc     = 1'b1;
      ctl.freeze_if_id  = 1'b1;
      ctl.bubble_id_exe = 1'b0;
      ctl.flush_if_id   = 1'b0;
    end

    if (!rst) begin
      ctl = '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.stat_clr),
    .inc   (ctl.freeze_pc),
    .count (stall_count)
  );

  assign bus.freeze_pc     = ctl.freeze_pc;
  assign bus.freeze_if_id  = ctl.freeze_if_id;
  assign bus.bubble_id_exe = ctl.bubble_id_exe;
  assign bus.flush_if_id   = ctl.flush_if_id;
  assign bus.freeze_all    = ctl.freeze_all;
  assign bus.mem_timeout   = mem_timeout_q;
  assign bus.stall_count   = stall_count;
  assign bus.ctrl_state    = state;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus random traffic,
// all outputs compared every cycle against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

  localparam int TO = 8;
  localparam int CW = 4;
  localparam int W  = 8 + CW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Model: access in progress, sticky timeout, not-ready run length, counter.
  bit m_wait = 1'b0;
  bit m_to   = 1'b0;
  int m_nr   = 0;
  int m_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic h, input logic b, input logic m, input logic r,
                       input logic c, input logic rv);
    logic fpc, fif, bub, fl, fa;
    logic [1:0] st;
    logic [W-1:0] e, got;
    @(negedge clk);
    bus.hazard_detected = h;
    bus.branch_taken    = b;
    bus.mem_req         = m;
    bus.sram_ready      = r;
    bus.stat_clr        = c;
    rst                 = rv;
    fpc = 0; fif = 0; bub = 0; fl = 0; fa = 0;
    if (rv) begin
      if (m_to || ((m_wait || m) && !r)) fa = 1;
      else if (b) begin fl = 1; bub = 1; end
      else if (h) begin fpc = 1; fif = 1; bub = 1; end
      if (fa) begin fpc = 1; fif = 1; end
    end
    st = m_to ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    exp_q.push_back({fpc, fif, bub, fl, fa, m_to, st, CW'(m_cnt)});
    #1;
    got = {bus.freeze_pc, bus.freeze_if_id, bus.bubble_id_exe, bus.flush_if_id,
           bus.freeze_all, bus.mem_timeout, bus.ctrl_state, bus.stall_count};
    e = exp_q.pop_front();
    check_eq("freeze_pc",     32'(got[W-1]),      32'(e[W-1]));
    check_eq("freeze_if_id",  32'(got[W-2]),      32'(e[W-2]));
    check_eq("bubble_id_exe", 32'(got[W-3]),      32'(e[W-3]));
    check_eq("flush_if_id",   32'(got[W-4]),      32'(e[W-4]));
    check_eq("freeze_all",    32'(got[W-5]),      32'(e[W-5]));
    check_eq("mem_timeout",   32'(got[W-6]),      32'(e[W-6]));
    check_eq("ctrl_state",    32'(got[W-7:W-8]),  32'(e[W-7:W-8]));
    check_eq("stall_count",   32'(got[CW-1:0]),   32'(e[CW-1:0]));
    if (!rv) begin
      m_wait = 0; m_to = 0; m_nr = 0; m_cnt = 0;
    end else begin
      if (!m_to) begin
        if (fa) begin
          m_nr++;
          if (m_nr >= TO) begin m_to = 1; m_wait = 0; end
          else m_wait = 1;
        end else begin
          m_wait = 0; m_nr = 0;
        end
      end
      if (c) m_cnt = 0;
      else if (fpc && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int p;
    bus.hazard_detected = 0; bus.branch_taken = 0; bus.mem_req = 0;
    bus.sram_ready = 0; bus.stat_clr = 0; rst = 0;

    do_reset();
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("rst_state", 32'(bus.ctrl_state), 0);
    check_eq("rst_cnt", 32'(bus.stall_count), 0);

    // Two-cycle load-use stall.
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("hz_drop", 32'(bus.freeze_pc), 0);
    check_eq("hz_cnt", 32'(bus.stall_count), 2);

    // Branch wins over hazard, no stall counted.
    cycle(1, 1, 0, 0, 0, 1);
    check_eq("br_flush", 32'(bus.flush_if_id), 1);
    check_eq("br_nofrz", 32'(bus.freeze_pc), 0);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("br_cnt", 32'(bus.stall_count), 2);

    // Four-cycle SRAM access with branches in cycles 2 and 4.
    do_reset();
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 1);
    check_eq("mem_c2_frz", 32'(bus.freeze_all), 1);
    check_eq("mem_c2_noflush", 32'(bus.flush_if_id), 0);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 1, 1, 1, 0, 1);
    check_eq("mem_c4_flush", 32'(bus.flush_if_id), 1);
    check_eq("mem_c4_nofrz", 32'(bus.freeze_all), 0);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("mem_state", 32'(bus.ctrl_state), 0);
    check_eq("mem_cnt", 32'(bus.stall_count), 3);

    // Single-cycle access: no freeze, no state change.
    cycle(0, 0, 1, 1, 0, 1);
    check_eq("mem_n1_frz", 32'(bus.freeze_all), 0);

    // Watchdog trip after TO not-ready cycles.
    do_reset();
    for (int i = 0; i < TO; i++) cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    check_eq("to_flag", 32'(bus.mem_timeout), 1);
    check_eq("to_state", 32'(bus.ctrl_state), 2);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, 0, 1);
    check_eq("to_sticky", 32'(bus.mem_timeout), 1);
    do_reset();
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("to_clr", 32'(bus.mem_timeout), 0);

    // Ready in the TO-th cycle completes normally.
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("to_edge_state", 32'(bus.ctrl_state), 0);

    // Counter saturation and clear priority.
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("sat_15", 32'(bus.stall_count), 15);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("sat_hold", 32'(bus.stall_count), 15);
    cycle(1, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("sat_clr", 32'(bus.stall_count), 0);

    // Reset in the middle of a wait.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 0);
    check_eq("rw_frz", 32'(bus.freeze_all), 0);
    check_eq("rw_fpc", 32'(bus.freeze_pc), 0);
    check_eq("rw_flush", 32'(bus.flush_if_id), 0);
    cycle(0, 0, 1, 1, 0, 1);
    check_eq("rw_state", 32'(bus.ctrl_state), 0);
    check_eq("rw_nofrz", 32'(bus.freeze_all), 0);

    // Random traffic with varying SRAM latency profiles.
    p = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: p = 10;
          1: p = 50;
          default: p = 90;
        endcase
      end
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < p),
            1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 79) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
